// File: rtl/conv_window_feeder.sv
// Raster-order pixel stream to 3x3 window feeder for the convolution engine.
// Two line buffers build each window; one result is returned per valid window.
module conv_window_feeder #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [71:0] conv_data,
  output logic        conv_start,
  input  logic [23:0] conv_result,
  input  logic        conv_done,
  output logic [23:0] res_data,
  output logic        res_valid,
  output logic        res_last,
  output logic        err
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_COOL   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cool_q, cool_d;
  logic [71:0]   win_q, win_d;
  logic [71:0]   data_q, data_d;
  logic          start_q, start_d;
  logic          ready_q, ready_d;
  logic [23:0]   res_q, res_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic          last_win_q, last_win_d;

  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    top_s, mid_s;
  logic          xfer_s;

  assign xfer_s = pix_valid && ready_q;
  assign top_s  = lb1[col_q];
  assign mid_s  = lb0[col_q];

  // Line buffers: rows r-1 and r-2, written only on a pixel transfer
  always_ff @(posedge clk) begin
    if (!reset && xfer_s) begin
      lb1[col_q] <= mid_s;
      lb0[col_q] <= pix_in;
    end
  end

  // Next-state, window build, handshake and result capture
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    tmo_d      = tmo_q;
    cool_d     = cool_q;
    win_d      = win_q;
    data_d     = data_q;
    res_d      = res_q;
    vld_d      = 1'b0;
    last_d     = 1'b0;
    err_d      = err_q;
    last_win_d = last_win_q;

    case (state_q)
      ST_ACCEPT: begin
        if (xfer_s) begin
          // Shift window left; right column becomes {top, mid, current}
          win_d = {pix_in, win_q[71:64], win_q[63:56],
                   mid_s,  win_q[47:40], win_q[39:32],
                   top_s,  win_q[23:16], win_q[15:8]};
          if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            if (row_q == RW'(IMG_H - 1)) begin
              row_d = '0;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
          if ((row_q >= RW'(2)) && (col_q >= CW'(2))) begin
            data_d     = win_d;
            last_win_d = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
            tmo_d      = '0;
            state_d    = ST_ISSUE;
          end else begin
            state_d = ST_ACCEPT;
          end
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_ISSUE: begin
        if (conv_done) begin
          res_d   = conv_result;
          vld_d   = 1'b1;
          last_d  = last_win_q;
          cool_d  = 1'b0;
          state_d = ST_COOL;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cool_d  = 1'b0;
          state_d = ST_COOL;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_COOL: begin
        if (cool_q) begin
          state_d = ST_ACCEPT;
        end else begin
          cool_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase

    start_d = (state_d == ST_ISSUE);
    ready_d = (state_d == ST_ACCEPT);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ACCEPT;
      col_q      <= '0;
      row_q      <= '0;
      tmo_q      <= '0;
      cool_q     <= 1'b0;
      win_q      <= '0;
      data_q     <= '0;
      start_q    <= 1'b0;
      ready_q    <= 1'b0;
      res_q      <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      last_win_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      tmo_q      <= tmo_d;
      cool_q     <= cool_d;
      win_q      <= win_d;
      data_q     <= data_d;
      start_q    <= start_d;
      ready_q    <= ready_d;
      res_q      <= res_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      err_q      <= err_d;
      last_win_q <= last_win_d;
    end
  end

  assign pix_ready  = ready_q;
  assign conv_data  = data_q;
  assign conv_start = start_q;
  assign res_data   = res_q;
  assign res_valid  = vld_q;
  assign res_last   = last_q;
  assign err        = err_q;

endmodule
